// File: rtl/pcread_arbiter_if.sv
// pcread_arbiter_if: bundles the three byte streams around the PC-read arbiter.
//   command decoder side : cmd_req / cmd_read / cmd_data in, cmd_hold / cmd_err out
//   hit FIFO side        : hit_count / hit_data in, hit_rd out
//   PC-read FIFO side    : out_full in, out_wr / out_data out
// slave  = the arbiter's view, master = the environment driving it.
interface pcread_arbiter_if #(
  parameter int COUNT_W = 10
);
  logic               cmd_req;
  logic               cmd_read;
  logic [7:0]         cmd_data;
  logic               cmd_hold;
  logic               cmd_err;

  logic [COUNT_W-1:0] hit_count;
  logic [7:0]         hit_data;
  logic               hit_rd;

  logic               out_full;
  logic               out_wr;
  logic [7:0]         out_data;

  modport slave (
    input  cmd_req, cmd_read, cmd_data,
    input  hit_count, hit_data,
    input  out_full,
    output cmd_hold, cmd_err,
    output hit_rd,
    output out_wr, out_data
  );

  modport master (
    output cmd_req, cmd_read, cmd_data,
    output hit_count, hit_data,
    output out_full,
    input  cmd_hold, cmd_err,
    input  hit_rd,
    input  out_wr, out_data
  );
endinterface

// File: rtl/pcread_arbiter.sv
// pcread_arbiter: multiplexes command readback bytes and framed hit packets
// into the single PC-read FIFO, switching only at packet/command boundaries.
// Optional feature macro: PCREAD_ARB_TIMESTAMP_EN -- inserts a 16-bit
// timestamp (high byte first) between the hit header and the payload.
//
// state    | code | meaning
// ---------+------+---------------------------------------------------
// IDLE     | 0    | choose next source; command wins over hit data
// CMD      | 1    | forward decoder strobes until cmd_req drops
// HIT_HDR  | 2    | write the packet header byte
// HIT_TS   | 3    | write timestamp hi then lo (timestamp build only)
// HIT_PAY  | 4    | pop/forward PKT_BYTES payload bytes
module pcread_arbiter #(
  parameter int         PKT_BYTES = 8,
  parameter logic [7:0] HIT_HDR   = 8'hA5,
  parameter int         COUNT_W   = 10
) (
  input  logic               clk,
  input  logic               res,
  pcread_arbiter_if.slave    bus,
  output logic [15:0]        hit_pkt_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_HIT_HDR = 3'd2,
    S_HIT_TS  = 3'd3,
    S_HIT_PAY = 3'd4
  } state_t;

  localparam logic [7:0]         LAST_IDX  = 8'(PKT_BYTES - 1);
  localparam logic [COUNT_W-1:0] START_LVL = COUNT_W'(PKT_BYTES);

  state_t     state;
  logic [7:0] byte_cnt;
  logic       cmd_err_q;
  logic       hit_ready;
  logic       full;

  logic       out_wr_c;
  logic       hit_rd_c;
  logic [7:0] out_data_c;
  logic       cmd_hold_c;

`ifdef PCREAD_ARB_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_lat;
  logic        ts_lo;
`endif

  assign full = bus.out_full;
  // A packet only starts with a full payload already buffered, so the
  // payload phase can never run the hit FIFO dry.
  assign hit_ready = (bus.hit_count >= START_LVL);

`ifdef PCREAD_ARB_TIMESTAMP_EN
  // Free-running timestamp base, sampled when a header goes out.
  always_ff @(posedge clk or posedge res) begin
    if (res) ts_cnt <= 16'd0;
    else     ts_cnt <= ts_cnt + 16'd1;
  end
`endif

  // Output decode: byte source, write/pop strobes and decoder throttle.
  always_comb begin
    out_wr_c   = 1'b0;
    hit_rd_c   = 1'b0;
    out_data_c = 8'h00;
    cmd_hold_c = 1'b1;
    case (state)
      S_CMD: begin
        cmd_hold_c = full;
        out_wr_c   = bus.cmd_read & ~full;
        out_data_c = bus.cmd_data;
      end
      S_HIT_HDR: begin
        out_wr_c   = ~full;
        out_data_c = HIT_HDR;
      end
`ifdef PCREAD_ARB_TIMESTAMP_EN
      S_HIT_TS: begin
        out_wr_c   = ~full;
        out_data_c = ts_lo ? ts_lat[7:0] : ts_lat[15:8];
      end
`endif
      S_HIT_PAY: begin
        out_wr_c   = ~full;
        hit_rd_c   = ~full;
        out_data_c = bus.hit_data;
      end
      default: begin
        out_wr_c   = 1'b0;
      end
    endcase
  end

  assign bus.out_wr   = out_wr_c;
  assign bus.hit_rd   = hit_rd_c;
  assign bus.out_data = out_data_c;
  assign bus.cmd_hold = cmd_hold_c;
  assign bus.cmd_err  = cmd_err_q;
  assign state_dbg    = state;

  // Sequencer: arbitration at boundaries, packet byte counting, error flag.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= S_IDLE;
      byte_cnt    <= 8'd0;
      hit_pkt_cnt <= 16'd0;
      cmd_err_q   <= 1'b0;
`ifdef PCREAD_ARB_TIMESTAMP_EN
      ts_lat      <= 16'd0;
      ts_lo       <= 1'b0;
`endif
    end else begin
      // A strobe while throttled is a decoder protocol error; the byte is dropped.
      if (bus.cmd_read & cmd_hold_c) cmd_err_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.cmd_req)            state <= S_CMD;
          else if (hit_ready && !full) state <= S_HIT_HDR;
        end
        S_CMD: begin
          if (!bus.cmd_req) state <= S_IDLE;
        end
        S_HIT_HDR: begin
          if (!full) begin
            byte_cnt <= LAST_IDX;
`ifdef PCREAD_ARB_TIMESTAMP_EN
            ts_lat   <= ts_cnt;
            ts_lo    <= 1'b0;
            state    <= S_HIT_TS;
`else
            state    <= S_HIT_PAY;
`endif
          end
        end
`ifdef PCREAD_ARB_TIMESTAMP_EN
        S_HIT_TS: begin
          if (!full) begin
            ts_lo <= 1'b1;
            if (ts_lo) state <= S_HIT_PAY;
          end
        end
`endif
        S_HIT_PAY: begin
          if (!full) begin
            if (byte_cnt == 8'd0) begin
              state       <= S_IDLE;
              hit_pkt_cnt <= hit_pkt_cnt + 16'd1;
            end else begin
              byte_cnt <= byte_cnt - 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcread_arbiter.sv
// tb_pcread_arbiter: directed scenarios plus a randomized soak, all checked
// against a stream-level model (FIFO queue, packet byte budget, command bytes).
module tb_pcread_arbiter;

  localparam int         PKT_BYTES = 8;
  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         COUNT_W   = 10;
`ifdef PCREAD_ARB_TIMESTAMP_EN
  localparam int         PRE_LEN   = 3;
`else
  localparam int         PRE_LEN   = 1;
`endif
  localparam int         PKT_LEN   = PKT_BYTES + PRE_LEN;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] hit_pkt_cnt;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  pcread_arbiter_if #(.COUNT_W(COUNT_W)) bus ();

  pcread_arbiter #(
    .PKT_BYTES (PKT_BYTES),
    .HIT_HDR   (HDR),
    .COUNT_W   (COUNT_W)
  ) dut (
    .clk         (clk),
    .res         (res),
    .bus         (bus),
    .hit_pkt_cnt (hit_pkt_cnt),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] hq[$];
  logic [7:0] cmd_log[$];
  int  pkt_rem, ts_rem, model_pkts, wr_cnt, rd_cnt;
  bit  prev_req, exp_err, pop_pending;
  bit  s_wr, s_rd, s_hold, s_err;
  logic [7:0] s_dat;

`ifdef PCREAD_ARB_TIMESTAMP_EN
  logic [15:0] tb_cyc;
  logic [15:0] exp_ts;
  always_ff @(posedge clk or posedge res) begin
    if (res) tb_cyc <= 16'd0;
    else     tb_cyc <= tb_cyc + 16'd1;
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) hq.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive_fifo();
    bus.hit_count = COUNT_W'(hq.size());
    bus.hit_data  = (hq.size() > 0) ? hq[0] : 8'h00;
  endtask

  task automatic reset_checks();
    check("rst_wr",    32'(bus.out_wr),   32'd0);
    check("rst_rd",    32'(bus.hit_rd),   32'd0);
    check("rst_data",  32'(bus.out_data), 32'd0);
    check("rst_hold",  32'(bus.cmd_hold), 32'd1);
    check("rst_err",   32'(bus.cmd_err),  32'd0);
    check("rst_pkt",   32'(hit_pkt_cnt),  32'd0);
    check("rst_state", 32'(state_dbg),    32'd0);
  endtask

  task automatic do_reset();
    res = 1'b1;
    #1;
    reset_checks();
    bus.cmd_req  = 1'b0;
    bus.cmd_read = 1'b0;
    bus.cmd_data = 8'h00;
    bus.out_full = 1'b0;
    hq.delete();
    cmd_log.delete();
    drive_fifo();
    pkt_rem = 0; ts_rem = 0; model_pkts = 0; wr_cnt = 0; rd_cnt = 0;
    prev_req = 1'b0; exp_err = 1'b0; pop_pending = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
  endtask

  // Stream-level scoreboard, evaluated mid-cycle with inputs stable.
  task automatic observe();
    s_wr   = bus.out_wr;
    s_rd   = bus.hit_rd;
    s_dat  = bus.out_data;
    s_hold = bus.cmd_hold;
    s_err  = bus.cmd_err;

    check("pkt_cnt", 32'(hit_pkt_cnt), 32'(model_pkts[15:0]));
    check("cmd_err", 32'(s_err), 32'(exp_err));
    if (bus.out_full) begin
      check("wr_full",   32'(s_wr),   32'd0);
      check("rd_full",   32'(s_rd),   32'd0);
      check("hold_full", 32'(s_hold), 32'd1);
    end
    if (pkt_rem > 0 || ts_rem > 0) check("hold_pkt", 32'(s_hold), 32'd1);
    if (!prev_req)                  check("hold_noreq", 32'(s_hold), 32'd1);
    if (!bus.out_full && (pkt_rem > 0 || ts_rem > 0)) check("pkt_gap", 32'(s_wr), 32'd1);

    if (bus.cmd_read && !s_hold) begin
      check("cmd_wr",  32'(s_wr),  32'd1);
      check("cmd_dat", 32'(s_dat), 32'(bus.cmd_data));
      check("cmd_rd",  32'(s_rd),  32'd0);
      cmd_log.push_back(s_dat);
    end else if (s_wr) begin
`ifdef PCREAD_ARB_TIMESTAMP_EN
      if (ts_rem > 0) begin
        check("ts_byte", 32'(s_dat), 32'((ts_rem == 2) ? exp_ts[15:8] : exp_ts[7:0]));
        check("ts_rd",   32'(s_rd),  32'd0);
        ts_rem--;
      end else
`endif
      if (pkt_rem > 0) begin
        if (hq.size() > 0) check("pay_dat", 32'(s_dat), 32'(hq[0]));
        else               check("pay_underflow", 32'(hq.size()), 32'd1);
        check("pay_rd", 32'(s_rd), 32'd1);
        pkt_rem--;
        if (pkt_rem == 0) model_pkts++;
      end else begin
        check("hdr",    32'(s_dat), 32'(HDR));
        check("hdr_rd", 32'(s_rd),  32'd0);
        pkt_rem = PKT_BYTES;
`ifdef PCREAD_ARB_TIMESTAMP_EN
        ts_rem = 2;
        exp_ts = tb_cyc;
`endif
      end
    end else begin
      check("rd_nowr", 32'(s_rd), 32'd0);
    end

    if (bus.cmd_read && s_hold) exp_err = 1'b1;
    if (s_rd) pop_pending = 1'b1;
    prev_req = bus.cmd_req;
    if (s_wr) wr_cnt++;
    if (s_rd) rd_cnt++;
  endtask

  // One clock: apply FIFO pop and new inputs after the edge, then observe.
  task automatic cycle(input bit full, input bit req, input bit rdc,
                       input logic [7:0] cd, input bit gate);
    @(posedge clk);
    #1;
    if (pop_pending && hq.size() > 0) void'(hq.pop_front());
    pop_pending  = 1'b0;
    drive_fifo();
    bus.out_full = full;
    bus.cmd_req  = req;
    bus.cmd_data = cd;
    bus.cmd_read = 1'b0;
    #1;
    bus.cmd_read = gate ? (rdc && !bus.cmd_hold) : rdc;
    @(negedge clk);
    observe();
  endtask

  initial begin
    int first, last, n, left;
    bit req, full, rdc;
    logic [7:0] cmd_bytes[4];

    res          = 1'b1;
    bus.cmd_req  = 1'b0;
    bus.cmd_read = 1'b0;
    bus.cmd_data = 8'h00;
    bus.out_full = 1'b0;
    bus.hit_count = '0;
    bus.hit_data  = 8'h00;

    // Plain packet: header then payload on consecutive cycles.
    do_reset();
    push_bytes(PKT_BYTES);
    first = -1; last = -1;
    for (int i = 0; i < PKT_LEN + 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (s_wr && first < 0) first = i;
      if (s_wr) last = i;
    end
    check("t2_first",  32'(first),       32'd1);
    check("t2_last",   32'(last),        32'(PKT_LEN));
    check("t2_wrs",    32'(wr_cnt),      32'(PKT_LEN));
    check("t2_pops",   32'(rd_cnt),      32'(PKT_BYTES));
    check("t2_pkt",    32'(hit_pkt_cnt), 32'd1);
    check("t2_state",  32'(state_dbg),   32'd0);

    // Command burst: one-cycle entry stall, then four bytes through.
    do_reset();
    cmd_bytes[0] = 8'h11; cmd_bytes[1] = 8'h22; cmd_bytes[2] = 8'h33; cmd_bytes[3] = 8'h44;
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t3_entry_hold",  32'(s_hold),    32'd1);
    check("t3_entry_state", 32'(state_dbg), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, cmd_bytes[i], 1'b0);
      check("t3_hold_lo", 32'(s_hold),    32'd0);
      check("t3_state",   32'(state_dbg), 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t3_drop_state", 32'(state_dbg), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t3_idle",  32'(state_dbg), 32'd0);
    check("t3_count", 32'(cmd_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) check("t3_byte", 32'(cmd_log[i]), 32'(cmd_bytes[i]));
    check("t3_err", 32'(s_err), 32'd0);

    // Command request arriving mid-packet waits for the packet boundary.
    do_reset();
    push_bytes(PKT_BYTES);
    req = 1'b0;
    for (int i = 0; i < 40 && model_pkts == 0; i++) begin
      cycle(1'b0, req, 1'b0, 8'h00, 1'b0);
      if (wr_cnt >= PRE_LEN + 2) req = 1'b1;
    end
    check("t4_done", 32'(model_pkts), 32'd1);
    check("t4_cmdlog", 32'(cmd_log.size()), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_idle_state", 32'(state_dbg), 32'd0);
    check("t4_idle_hold",  32'(s_hold),    32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_cmd_state",  32'(state_dbg), 32'd1);
    check("t4_cmd_hold",   32'(s_hold),    32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Two full cycles mid-payload: exactly two stalls, no state change.
    do_reset();
    push_bytes(PKT_BYTES);
    for (int i = 0; i < 40 && wr_cnt < PRE_LEN + 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t5_reach", 32'(wr_cnt), 32'(PRE_LEN + 3));
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check("t5_stall_wr",    32'(s_wr),      32'd0);
      check("t5_stall_rd",    32'(s_rd),      32'd0);
      check("t5_stall_state", 32'(state_dbg), 32'd4);
    end
    n = 0;
    for (int i = 0; i < 30 && model_pkts == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    check("t5_tail", 32'(n), 32'(PKT_BYTES - 3));
    check("t5_pops", 32'(rd_cnt), 32'(PKT_BYTES));

    // Strobe while held is dropped and latched as an error; reset clears it.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    check("t6_drop_wr",   32'(s_wr),   32'd0);
    check("t6_drop_hold", 32'(s_hold), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t6_err_set", 32'(s_err), 32'd1);
    push_bytes(PKT_BYTES);
    for (int i = 0; i < 40 && wr_cnt < PRE_LEN + 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t6_err_hold",  32'(s_err),     32'd1);
    check("t6_mid_state", 32'(state_dbg), 32'd4);
    do_reset();

    // Randomized soak: random full, hit traffic and well-behaved command bursts.
    req = 1'b0; left = 0;
    for (int i = 0; i < 4000; i++) begin
      full = ($urandom_range(0, 3) == 0);
      if (hq.size() < 30 && $urandom_range(0, 5) == 0) push_bytes($urandom_range(1, 6));
      if (!req && left == 0 && $urandom_range(0, 24) == 0) begin
        req  = 1'b1;
        left = $urandom_range(1, 6);
      end
      rdc = req && (left > 0) && ($urandom_range(0, 1) == 1);
      cycle(full, req, rdc, 8'($urandom_range(0, 255)), 1'b1);
      if (bus.cmd_read) left--;
      if (req && left == 0 && !bus.cmd_read) req = 1'b0;
    end
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("rand_drained", 32'(hq.size() < PKT_BYTES), 32'd1);
    check("rand_state",   32'(state_dbg), 32'd0);
    check("rand_err",     32'(s_err),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcread_arbiter.md
# pcread_arbiter

Arbiter and sequencer for the single PC-read FIFO that feeds the FTDI transmit path. It multiplexes two sources into that FIFO: register readback bytes produced by the command decoder during read commands, and framed hit-data packets drained from the hit FIFO. Arbitration happens only at packet or command boundaries, so byte streams never interleave. It also produces the hold/throttle flag that the command decoder uses as its "PC FIFO full" input.

## Interface
Parameters:
- PKT_BYTES, 8: hit payload bytes per packet (1..255)
- HIT_HDR, 8'hA5: header byte prepended to every hit packet
- COUNT_W, 10: width of hit FIFO fill count

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous, active-high reset
- cmd_req  in  1  decoder is in a read-command value phase (burst active)
- cmd_read  in  1  decoder byte strobe; cmd_data valid this cycle
- cmd_data  in  8  readback byte
- cmd_hold  out  1  to decoder FIFO-full input; decoder must not strobe while high
- cmd_err  out  1  sticky: cmd_read seen while cmd_hold high
- hit_count  in  COUNT_W  bytes currently in hit FIFO (first-word-fall-through)
- hit_data  in  8  hit FIFO head byte
- hit_rd  out  1  hit FIFO pop
- out_full  in  1  PC-read FIFO full
- out_wr  out  1  PC-read FIFO write
- out_data  out  8  PC-read FIFO data
- hit_pkt_cnt  out  16  completed hit packets, wraps
- state_dbg  out  3  current state encoding

## Operation
- States: IDLE=0, CMD=1, HIT_HDR=2, HIT_TS=3 (macro only), HIT_PAY=4.
- IDLE: cmd_req → CMD (command has priority); else if hit_count ≥ PKT_BYTES and !out_full → HIT_HDR; else stay.
- CMD: out_wr = cmd_read & !cmd_hold; out_data = cmd_data. Stay while cmd_req; when cmd_req is low → IDLE.
- HIT_HDR: if !out_full, write HIT_HDR and load byte counter = PKT_BYTES-1 → HIT_PAY (or HIT_TS). If out_full, wait.
- HIT_PAY: if !out_full, hit_rd = out_wr = 1, out_data = hit_data. Counter==0 → IDLE and hit_pkt_cnt+1; else decrement.
- cmd_hold = out_full | (state != CMD). It is high in IDLE even when cmd_req is set, so the decoder stalls one cycle during entry.
- A cmd_req raised during a hit packet waits until the packet finishes. The hit path cannot starve because command bursts are finite.
- cmd_err is set on cmd_read & cmd_hold, and cleared only by res. The offending byte is dropped.
- out_wr, hit_rd and out_data are combinational from state and inputs. No byte is ever written while out_full is high.

## Timing
- Reset (asynchronous): state IDLE, counters 0, hit_pkt_cnt 0, cmd_err 0, out_wr 0, hit_rd 0, out_data 0, cmd_hold 1.
- Reset during a packet discards the remainder. Bytes already popped are lost, and the PC resynchronises on HIT_HDR.
- CMD latency: cmd_req sampled high in IDLE → CMD on the next edge; cmd_hold falls that cycle if !out_full.
- Hit packet: with no stalls, 1+PKT_BYTES consecutive out_wr cycles (+2 with the macro). Each out_full cycle inserts exactly one stall with no state change.
- hit_count is evaluated only in IDLE. A mid-packet underflow cannot occur because of the start condition.
- hit_pkt_cnt wraps from 16'hFFFF to 0.

## Configuration
- PCREAD_ARB_TIMESTAMP_EN defined:
  - A free-running 16-bit counter (reset 0, wraps) is latched when HIT_HDR is written.
  - HIT_TS writes timestamp[15:8] then timestamp[7:0], each gated by out_full, then enters HIT_PAY.
  - Packet length is PKT_BYTES+3.
- Undefined: HIT_TS and the counter are absent; HIT_HDR → HIT_PAY directly; packet length is PKT_BYTES+1.

## Test plan
- PKT_BYTES=8, hit_count=8, out_full=0 → out_wr on 9 consecutive cycles: A5 then payload; 8 hit_rd pulses; hit_pkt_cnt=1; back in IDLE.
- cmd_req high with 4 cmd_read strobes (11,22,33,44) → CMD after 1 cycle; four writes of exactly those bytes; IDLE after cmd_req drops; cmd_err=0.
- cmd_req rises on payload byte 3 → cmd_hold stays 1 until the packet completes; CMD is entered the cycle after IDLE; no interleaved bytes.
- out_full pulsed high 2 cycles mid-payload → exactly 2 stall cycles; no write or pop while full; full payload order preserved.
- cmd_read while in IDLE → byte dropped, cmd_err=1 until res; res asserted mid-packet → all outputs at reset values immediately.
- With PCREAD_ARB_TIMESTAMP_EN: packet is A5, ts_hi, ts_lo, payload; the timestamp equals the counter value latched at header write.
